// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the hazard scoreboard.
//   REG_ADDR_W : architectural register address width
//   LAT_W_DEF  : default countdown width (max producer latency 2**LAT_W_DEF-1)
//   NUM_ADDR   : number of addressable registers (2**REG_ADDR_W)
//   lat_t      : countdown / latency value at the default width
//   reg_addr_t : register address
//   REG_X0     : hard-wired zero register, never tracked
package hazard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int LAT_W_DEF  = 4;
  localparam int NUM_ADDR   = 2 ** REG_ADDR_W;

  typedef logic [LAT_W_DEF-1:0]  lat_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_X0 = '0;
endpackage

// File: rtl/hazard_reg_timer.sv
// hazard_reg_timer
//   Countdown for one architectural register. Holds the number of cycles a
//   dependent instruction must still wait before it may read the register.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     load         start a new countdown with load_val (wins over decrement)
//     load_val     new countdown value
//     decrement    age a non-zero count by one
//     freeze       hold the count, including a pending load
//     count        current countdown value
//     nonzero      count != 0
module hazard_reg_timer
  import hazard_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             decrement,
  input  logic             freeze,
  output logic [LAT_W-1:0] count,
  output logic             nonzero
);

  logic [LAT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt_q <= load_val;
      end else if (decrement && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign count   = cnt_q;
  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Interlock unit beside the ID stage. Every written register gets a
//   countdown of the producer latency; ID instructions reading a register
//   with a live countdown (RAW) or writing one whose countdown outlives
//   their own latency (WAW) are held, and a bubble goes into ID/EX.
//   Optional feature macro: HAZARD_PERF_CNT_EN (stall cycle/event counters).
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     id_valid, id_kill   ID instruction valid / squashed this cycle
//     pipe_freeze         whole-pipe hold; every countdown is held
//     id_rs_addr/used     NUM_SRC source addresses and read enables
//     id_rd_addr, id_we   destination and write enable
//     id_lat              cycles a dependent must wait (0 = no entry)
//     stall, id_ex_flush  hold PC/IF-ID, insert ID/EX bubble
//     stall_src, waw_stall per-source RAW mask, WAW cause
//     busy                any countdown live
//     perf_stall_cycles/events  stall statistics (0 when feature disabled)
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int LAT_W    = LAT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic                          id_kill,
  input  logic                          pipe_freeze,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd_addr,
  input  logic                          id_we,
  input  logic [LAT_W-1:0]              id_lat,
  output logic                          stall,
  output logic                          id_ex_flush,
  output logic [NUM_SRC-1:0]            stall_src,
  output logic                          waw_stall,
  output logic                          busy,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_stall_events
);

  logic [LAT_W-1:0]    cnt [NUM_ADDR];
  logic [NUM_ADDR-1:0] nz;
  logic                id_live;
  logic                issue;
  reg_addr_t           src_addr;

  assign id_live = id_valid & ~id_kill;

  // The table spans the full address space so any 5-bit address indexes
  // safely; untracked entries (x0 and anything >= NUM_REGS) read as zero.
  for (genvar r = 0; r < NUM_ADDR; r++) begin : g_reg
    if (r == 0 || r >= NUM_REGS) begin : g_none
      assign cnt[r] = '0;
      assign nz[r]  = 1'b0;
    end else begin : g_timer
      logic load;
      assign load = issue & id_we & (id_rd_addr == reg_addr_t'(r)) & (id_lat != '0);

      hazard_reg_timer #(.LAT_W(LAT_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_val  (id_lat),
        .decrement (1'b1),
        .freeze    (pipe_freeze),
        .count     (cnt[r]),
        .nonzero   (nz[r])
      );
    end
  end

  always_comb begin
    stall_src = '0;
    src_addr  = REG_X0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_addr     = id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
      stall_src[i] = id_live & id_rs_used[i] & (src_addr != REG_X0) & (cnt[src_addr] != '0);
    end
  end

  // A later writer may issue once its own result would land no earlier
  // than the outstanding one, i.e. when the remaining count <= id_lat.
  assign waw_stall   = id_live & id_we & (id_rd_addr != REG_X0) & (cnt[id_rd_addr] > id_lat);
  assign stall       = (|stall_src) | waw_stall;
  assign id_ex_flush = stall & ~pipe_freeze;
  assign issue       = id_live & ~stall & ~pipe_freeze;
  assign busy        = |nz;

`ifdef HAZARD_PERF_CNT_EN
  logic        stall_q;
  logic [31:0] cycles_q;
  logic [31:0] events_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= 1'b0;
      cycles_q <= '0;
      events_q <= '0;
    end else begin
      stall_q <= stall;
      if (stall && !pipe_freeze && (cycles_q != '1)) begin
        cycles_q <= cycles_q + 32'd1;
      end
      if (stall && !stall_q && (events_q != '1)) begin
        events_q <= events_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = cycles_q;
  assign perf_stall_events = events_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_stall_events = 32'd0;
`endif

endmodule
